// File: rtl/core_if_fetch.sv
// Instruction fetch unit: owns the PC, issues word-aligned requests to instruction
// memory, pairs in-order responses with their PC and buffers them for the ID stage.
// Redirects from EX flush the buffer and turn in-flight responses into stale drops.
module core_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch request channel
  output logic        o_ifu_req_valid,
  input  logic        i_ifu_req_ready,
  output logic [31:0] o_ifu_req_addr,
  // Fetch response channel (always accepted)
  input  logic        i_ifu_rsp_valid,
  input  logic [31:0] i_ifu_rsp_inst,
  input  logic        i_ifu_rsp_err,
  // Redirect from EX
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  // Toward core_id_decode
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc,
  output logic        o_id_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  // Architectural PC
  logic [31:0] pc_q, pc_d;

  // Pending-address queue: PCs of live requests, in issue order
  logic [31:0]     paq_q [DEPTH];
  logic [31:0]     paq_d [DEPTH];
  logic [PtrW-1:0] paq_wr_q, paq_wr_d;
  logic [PtrW-1:0] paq_rd_q, paq_rd_d;

  // Instruction buffer toward ID
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_pc_d   [DEPTH];
  logic [31:0]     fifo_inst_q [DEPTH];
  logic [31:0]     fifo_inst_d [DEPTH];
  logic            fifo_err_q  [DEPTH];
  logic            fifo_err_d  [DEPTH];
  logic [PtrW-1:0] fifo_wr_q, fifo_wr_d;
  logic [PtrW-1:0] fifo_rd_q, fifo_rd_d;

  // Bookkeeping counters
  logic [CntW-1:0] live_q, live_d;  // outstanding requests whose data is wanted
  logic [CntW-1:0] drop_q, drop_d;  // outstanding requests orphaned by a redirect
  logic [CntW-1:0] cnt_q, cnt_d;    // buffer occupancy

  logic        req_fire;
  logic        rsp_keep;
  logic        id_pop;
  logic        buf_credit_ok;
  logic        out_credit_ok;
  logic [31:0] redirect_pc_aligned;
  logic [CntW:0] buf_claim;
  logic [CntW:0] out_claim;

  assign redirect_pc_aligned = i_redirect_pc & ~32'h3;

  // Request gating and handshake decode
  always_comb begin
    o_id_valid = (cnt_q != '0);
    id_pop     = o_id_valid & i_id_ready & ~i_redirect_valid;
    rsp_keep   = i_ifu_rsp_valid & (drop_q == '0);

    // A slot freed by this cycle's ID pop is already usable, which keeps the
    // stream at one instruction per cycle with a two-entry buffer.
    buf_claim     = {1'b0, live_q} + {1'b0, cnt_q} - (CntW + 1)'(id_pop);
    out_claim     = {1'b0, live_q} + {1'b0, drop_q};
    buf_credit_ok = (buf_claim < DepthW);
    out_credit_ok = (out_claim < DepthW);

    o_ifu_req_valid = ~rst & ~i_redirect_valid & buf_credit_ok & out_credit_ok;
    o_ifu_req_addr  = pc_q;
    req_fire        = o_ifu_req_valid & i_ifu_req_ready;
  end

  // Buffer head drives ID directly from storage, so it holds steady while stalled
  always_comb begin
    o_id_pc   = fifo_pc_q[fifo_rd_q];
    o_id_inst = fifo_inst_q[fifo_rd_q];
    o_id_err  = fifo_err_q[fifo_rd_q];
  end

  // Next-state: redirect flushes everything, otherwise issue / respond / pop
  always_comb begin
    pc_d        = pc_q;
    paq_d       = paq_q;
    paq_wr_d    = paq_wr_q;
    paq_rd_d    = paq_rd_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    fifo_err_d  = fifo_err_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    live_d      = live_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;

    if (i_redirect_valid) begin
      pc_d      = redirect_pc_aligned;
      paq_wr_d  = '0;
      paq_rd_d  = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      cnt_d     = '0;
      live_d    = '0;
      // Every live request becomes stale; a response landing now is one of them.
      drop_d    = drop_q + live_q - CntW'(i_ifu_rsp_valid);
    end else begin
      if (req_fire) begin
        paq_d[paq_wr_q] = pc_q;
        paq_wr_d        = paq_wr_q + PtrW'(1);
        pc_d            = pc_q + 32'd4;
      end

      if (i_ifu_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else begin
          fifo_pc_d[fifo_wr_q]   = paq_q[paq_rd_q];
          fifo_inst_d[fifo_wr_q] = i_ifu_rsp_inst;
          fifo_err_d[fifo_wr_q]  = i_ifu_rsp_err;
          fifo_wr_d              = fifo_wr_q + PtrW'(1);
          paq_rd_d               = paq_rd_q + PtrW'(1);
        end
      end

      if (id_pop) begin
        fifo_rd_d = fifo_rd_q + PtrW'(1);
      end

      live_d = live_q + CntW'(req_fire) - CntW'(rsp_keep);
      cnt_d  = cnt_q + CntW'(rsp_keep) - CntW'(id_pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      paq_wr_q  <= '0;
      paq_rd_q  <= '0;
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      live_q    <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        paq_q[i]       <= '0;
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      pc_q        <= pc_d;
      paq_q       <= paq_d;
      paq_wr_q    <= paq_wr_d;
      paq_rd_q    <= paq_rd_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_err_q  <= fifo_err_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      live_q      <= live_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_core_if_fetch.sv
// Bench for core_if_fetch: a directed vector table, a few hand-written corner
// sequences, and a randomized run against an in-order memory and program-order model.
module tb_core_if_fetch;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int NVec = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_ifu_req_valid;
  logic        i_ifu_req_ready;
  logic [31:0] o_ifu_req_addr;
  logic        i_ifu_rsp_valid;
  logic [31:0] i_ifu_rsp_inst;
  logic        i_ifu_rsp_err;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_id_valid;
  logic        i_id_ready;
  logic [31:0] o_id_inst;
  logic [31:0] o_id_pc;
  logic        o_id_err;

  core_if_fetch #(
    .RESET_PC(ResetPc),
    .DEPTH   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .o_ifu_req_valid (o_ifu_req_valid),
    .i_ifu_req_ready (i_ifu_req_ready),
    .o_ifu_req_addr  (o_ifu_req_addr),
    .i_ifu_rsp_valid (i_ifu_rsp_valid),
    .i_ifu_rsp_inst  (i_ifu_rsp_inst),
    .i_ifu_rsp_err   (i_ifu_rsp_err),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_id_valid      (o_id_valid),
    .i_id_ready      (i_id_ready),
    .o_id_inst       (o_id_inst),
    .o_id_pc         (o_id_pc),
    .o_id_err        (o_id_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rr;      // i_ifu_req_ready
    logic        rv;      // i_ifu_rsp_valid
    logic [31:0] inst;
    logic        err;
    logic        redir;
    logic [31:0] rpc;
    logic        idr;     // i_id_ready
    logic        e_rv;    // expected o_ifu_req_valid
    logic [31:0] e_addr;
    logic        e_idv;
    logic        chk_id;  // compare head fields only when a head is presented
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_err;
  } vec_t;

  vec_t vecs [NVec];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q [$];
  logic [31:0] log_q [$];
  int          cyc = 0;
  int          last_due = 0;
  int          delivered = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_id;
  bit          after_redir = 1'b0;

  // Memory contents: a fixed scramble of the address, faults at one word per 64 B
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a[5:2] == 4'hB);
  endfunction

  function automatic vec_t mkv(
    input logic rr, input logic rv, input logic [31:0] inst, input logic err,
    input logic redir, input logic [31:0] rpc, input logic idr,
    input logic e_rv, input logic [31:0] e_addr, input logic e_idv,
    input logic chk_id, input logic [31:0] e_pc, input logic e_err);
    vec_t v;
    v.rr = rr; v.rv = rv; v.inst = inst; v.err = err;
    v.redir = redir; v.rpc = rpc; v.idr = idr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_idv = e_idv;
    v.chk_id = chk_id; v.e_pc = e_pc; v.e_inst = inst_of(e_pc); v.e_err = e_err;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic idle_inputs();
    i_ifu_req_ready  = 1'b0;
    i_ifu_rsp_valid  = 1'b0;
    i_ifu_rsp_inst   = '0;
    i_ifu_rsp_err    = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = '0;
    i_id_ready       = 1'b0;
  endtask

  // Reset for one cycle, check reset outputs, leave one idle cycle with rst low
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    chk1 ("rst_req_valid", o_ifu_req_valid, 1'b0);
    chk32("rst_req_addr",  o_ifu_req_addr,  ResetPc);
    chk1 ("rst_id_valid",  o_id_valid,      1'b0);
    chk32("rst_id_inst",   o_id_inst,       32'h0);
    chk32("rst_id_pc",     o_id_pc,         32'h0);
    chk1 ("rst_id_err",    o_id_err,        1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_q.delete();
    last_due    = cyc;
    exp_fetch   = ResetPc;
    exp_id      = ResetPc;
    after_redir = 1'b0;
  endtask

  // One cycle against the in-order memory and program-order reference
  task automatic step(input int p_rr, input int p_idr, input int kmin, input int kmax,
                      input bit redir, input logic [31:0] rpc);
    int k;
    int due;
    @(negedge clk);
    i_ifu_rsp_valid = 1'b0;
    i_ifu_rsp_inst  = '0;
    i_ifu_rsp_err   = 1'b0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        i_ifu_rsp_valid = 1'b1;
        i_ifu_rsp_inst  = inst_of(mem_q[0].addr);
        i_ifu_rsp_err   = err_of(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
    i_ifu_req_ready  = (int'($urandom_range(99)) < p_rr);
    i_id_ready       = (int'($urandom_range(99)) < p_idr);
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    #1;
    if (redir) chk1("redir_blocks_req", o_ifu_req_valid, 1'b0);
    if (after_redir) chk1("id_empty_after_redir", o_id_valid, 1'b0);
    if (o_ifu_req_valid) chk32("req_addr", o_ifu_req_addr, exp_fetch);
    if (o_id_valid) begin
      chk32("id_pc",   o_id_pc,   exp_id);
      chk32("id_inst", o_id_inst, inst_of(exp_id));
      chk1 ("id_err",  o_id_err,  err_of(exp_id));
    end
    if (o_id_valid && i_id_ready && !redir) begin
      log_q.push_back(o_id_pc);
      exp_id = exp_id + 32'd4;
      delivered++;
    end
    if (o_ifu_req_valid && i_ifu_req_ready) begin
      k   = kmin + int'($urandom_range(unsigned'(kmax - kmin)));
      due = (cyc + k > last_due + 1) ? cyc + k : last_due + 1;
      mem_q.push_back('{addr: o_ifu_req_addr, due: due});
      last_due  = due;
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      exp_fetch = rpc & ~32'h3;
      exp_id    = rpc & ~32'h3;
    end
    after_redir = redir;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            rr rv inst                    err rd rpc         idr  erv eaddr         eidv chk epc           eerr
    vecs[0]  = mkv(1, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h8000_0000, 0, 0, 32'h0,         0);
    vecs[1]  = mkv(1, 1, inst_of(32'h8000_0000), 0, 0, 32'h0,       1,   1, 32'h8000_0004, 0, 0, 32'h0,         0);
    vecs[2]  = mkv(1, 1, inst_of(32'h8000_0004), 0, 0, 32'h0,       1,   1, 32'h8000_0008, 1, 1, 32'h8000_0000, 0);
    vecs[3]  = mkv(1, 1, inst_of(32'h8000_0008), 1, 0, 32'h0,       1,   1, 32'h8000_000C, 1, 1, 32'h8000_0004, 0);
    vecs[4]  = mkv(1, 1, inst_of(32'h8000_000C), 0, 0, 32'h0,       0,   0, 32'h8000_0010, 1, 1, 32'h8000_0008, 1);
    vecs[5]  = mkv(1, 0, 32'h0,                  0, 0, 32'h0,       0,   0, 32'h8000_0010, 1, 1, 32'h8000_0008, 1);
    vecs[6]  = mkv(1, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h8000_0010, 1, 1, 32'h8000_0008, 1);
    vecs[7]  = mkv(0, 1, inst_of(32'h8000_0010), 0, 0, 32'h0,       1,   1, 32'h8000_0014, 1, 1, 32'h8000_000C, 0);
    vecs[8]  = mkv(0, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h8000_0014, 1, 1, 32'h8000_0010, 0);
    vecs[9]  = mkv(1, 0, 32'h0,                  0, 1, 32'h203,     1,   0, 32'h8000_0014, 0, 0, 32'h0,         0);
    vecs[10] = mkv(1, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h0000_0200, 0, 0, 32'h0,         0);
    vecs[11] = mkv(1, 1, inst_of(32'h0000_0200), 0, 0, 32'h0,       1,   1, 32'h0000_0204, 0, 0, 32'h0,         0);
    vecs[12] = mkv(0, 1, inst_of(32'h0000_0204), 0, 1, 32'h303,     1,   0, 32'h0000_0208, 1, 1, 32'h0000_0200, 0);
    vecs[13] = mkv(1, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h0000_0300, 0, 0, 32'h0,         0);
    vecs[14] = mkv(0, 1, inst_of(32'h0000_0300), 0, 0, 32'h0,       1,   1, 32'h0000_0304, 0, 0, 32'h0,         0);
    vecs[15] = mkv(0, 0, 32'h0,                  0, 0, 32'h0,       1,   1, 32'h0000_0304, 1, 1, 32'h0000_0300, 0);

    // Directed vector table, k=1 memory driven by hand
    do_reset();
    for (int i = 0; i < NVec; i++) begin
      @(negedge clk);
      i_ifu_req_ready  = vecs[i].rr;
      i_ifu_rsp_valid  = vecs[i].rv;
      i_ifu_rsp_inst   = vecs[i].inst;
      i_ifu_rsp_err    = vecs[i].err;
      i_redirect_valid = vecs[i].redir;
      i_redirect_pc    = vecs[i].rpc;
      i_id_ready       = vecs[i].idr;
      #1;
      chk1 ($sformatf("row%0d_req_valid", i), o_ifu_req_valid, vecs[i].e_rv);
      chk32($sformatf("row%0d_req_addr", i),  o_ifu_req_addr,  vecs[i].e_addr);
      chk1 ($sformatf("row%0d_id_valid", i),  o_id_valid,      vecs[i].e_idv);
      if (vecs[i].chk_id) begin
        chk32($sformatf("row%0d_id_pc", i),   o_id_pc,   vecs[i].e_pc);
        chk32($sformatf("row%0d_id_inst", i), o_id_inst, vecs[i].e_inst);
        chk1 ($sformatf("row%0d_id_err", i),  o_id_err,  vecs[i].e_err);
      end
    end

    // Redirect with two k=3 responses in flight: both must be discarded
    do_reset();
    step(100, 100, 3, 3, 1'b0, 32'h0);
    step(100, 100, 3, 3, 1'b0, 32'h0);
    chk32("k3_outstanding", mem_q.size(), 32'd2);
    log_q.delete();
    step(100, 100, 3, 3, 1'b1, 32'h100);
    for (int c = 0; c < 14; c++) step(100, 100, 3, 3, 1'b0, 32'h0);
    chk1("k3_log_len", (log_q.size() >= 2), 1'b1);
    if (log_q.size() >= 2) begin
      chk32("k3_first_pc",  log_q[0], 32'h100);
      chk32("k3_second_pc", log_q[1], 32'h104);
    end

    // ID stall: buffer fills, requests stop, then in-order delivery resumes
    do_reset();
    for (int c = 0; c < 4; c++) step(100, 100, 1, 1, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) step(100, 0, 1, 1, 1'b0, 32'h0);
    chk1("stall_req_dropped", o_ifu_req_valid, 1'b0);
    chk1("stall_head_valid",  o_id_valid,      1'b1);
    for (int c = 0; c < 10; c++) step(100, 100, 1, 1, 1'b0, 32'h0);

    // Memory not ready: address holds at the reset PC
    do_reset();
    log_q.delete();
    for (int c = 0; c < 5; c++) step(0, 100, 1, 1, 1'b0, 32'h0);
    chk32("hold_addr", o_ifu_req_addr, ResetPc);
    for (int c = 0; c < 8; c++) step(100, 100, 1, 1, 1'b0, 32'h0);
    chk1("hold_log_len", (log_q.size() >= 1), 1'b1);
    if (log_q.size() >= 1) chk32("hold_first_pc", log_q[0], ResetPc);

    // Randomized run with redirects and one mid-run reset
    do_reset();
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      if (c == 1500) do_reset();
      r = (int'($urandom_range(99)) < 3);
      step(70, 70, 1, 4, r, $urandom);
    end
    chk1("random_progress", (delivered > 200), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
